// File: rtl/core_pkg.sv
// Shared core definitions: datapath defaults, operand-select encodings and
// instruction field positions used by the decode/operand path.
package core_pkg;

   localparam int XLEN_DEFAULT   = 32;
   localparam int REG_AW_DEFAULT = 5;

   // Major opcode field of the raw instruction
   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 6;

   typedef enum logic [2:0] {
      IMM_RS2  = 3'b000,
      IMM_I    = 3'b001,
      IMM_B    = 3'b010,
      IMM_S    = 3'b011,
      IMM_U    = 3'b100,
      IMM_UJ   = 3'b101,
      IMM_FOUR = 3'b110,
      IMM_RSVD = 3'b111
   } imm_sel_e;

   typedef enum logic [1:0] {
      A_RS1  = 2'b00,
      A_PC   = 2'b01,
      A_ZERO = 2'b10,
      A_RSVD = 2'b11
   } a_sel_e;

endpackage

// File: rtl/operand_sel_stage_if.sv
// Decode-to-execute operand bus: decode-side request, execute-side response.
// master = the surrounding pipeline (drives requests, consumes operands),
// slave  = the operand select stage.
interface operand_sel_stage_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       inst;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   rs1;
   logic [XLEN-1:0]   rs2;
   logic [REG_AW-1:0] rs1_addr;
   logic [REG_AW-1:0] rs2_addr;
   logic [1:0]        a_sel;
   logic [2:0]        imme_sel;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   op_a;
   logic [XLEN-1:0]   op_b;
   logic [XLEN-1:0]   store_data;
   logic              sel_illegal;

   modport master (
      output in_valid, inst, pc, rs1, rs2, rs1_addr, rs2_addr, a_sel, imme_sel, out_ready,
      input  in_ready, out_valid, op_a, op_b, store_data, sel_illegal
   );

   modport slave (
      input  in_valid, inst, pc, rs1, rs2, rs1_addr, rs2_addr, a_sel, imme_sel, out_ready,
      output in_ready, out_valid, op_a, op_b, store_data, sel_illegal
   );
endinterface

// File: rtl/operand_sel_stage_imm_gen.sv
// imm_gen: combinational decode of every immediate format from a raw
// instruction, each sign-extended from inst[31] to XLEN. Shared with the
// branch unit.
module imm_gen
   import core_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]             inst,
   output logic signed [XLEN-1:0]  imm_i,
   output logic signed [XLEN-1:0]  imm_s,
   output logic signed [XLEN-1:0]  imm_b,
   output logic signed [XLEN-1:0]  imm_u,
   output logic signed [XLEN-1:0]  imm_uj
);
   logic signed [11:0] i12;
   logic signed [11:0] s12;
   logic signed [12:0] b13;
   logic signed [31:0] u32;
   logic signed [20:0] j21;
   logic               unused_opcode;

   // Assemble each format at its native width, then sign-extend by cast
   always_comb begin
      i12    = inst[31:20];
      s12    = {inst[31:25], inst[11:7]};
      b13    = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      u32    = {inst[31:12], 12'b0};
      j21    = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      imm_i  = XLEN'(i12);
      imm_s  = XLEN'(s12);
      imm_b  = XLEN'(b13);
      imm_u  = XLEN'(u32);
      imm_uj = XLEN'(j21);
   end

   // The opcode field carries no immediate bits
   assign unused_opcode = ^inst[OPC_MSB:OPC_LSB];

endmodule

// File: rtl/operand_sel_stage.sv
// operand_sel_stage: registered ALU operand select between decode and
// execute. Decodes immediates, optionally forwards EX/WB results onto
// rs1/rs2, selects op_a/op_b/store_data and holds them in a one-entry
// valid/ready pipe register.
// Build option: OPSEL_FWD_EN enables EX/WB forwarding; without it the
// register-file data is used directly and the hazard unit must stall.
module operand_sel_stage
   import core_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   operand_sel_stage_if.slave bus,
   input  logic               ex_wr_en,
   input  logic [REG_AW-1:0]  ex_rd,
   input  logic [XLEN-1:0]    ex_data,
   input  logic               wb_wr_en,
   input  logic [REG_AW-1:0]  wb_rd,
   input  logic [XLEN-1:0]    wb_data
);
   logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_uj;
   logic [XLEN-1:0]        rs1_f_p0, rs2_f_p0;
   logic [XLEN-1:0]        op_a_p0, op_b_p0;
   logic                   illegal_p0;
   logic                   accept_p0;
   logic                   in_ready;

   logic                   vld_p1;
   logic [XLEN-1:0]        op_a_p1, op_b_p1, store_data_p1;
   logic                   sel_illegal_p1;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst   (bus.inst),
      .imm_i  (imm_i),
      .imm_s  (imm_s),
      .imm_b  (imm_b),
      .imm_u  (imm_u),
      .imm_uj (imm_uj)
   );

`ifdef OPSEL_FWD_EN
   // EX beats WB beats the register file; x0 is never forwarded
   function automatic logic [XLEN-1:0] fwd_src(
      input logic [REG_AW-1:0] addr,
      input logic [XLEN-1:0]   rf,
      input logic              e_en,
      input logic [REG_AW-1:0] e_rd,
      input logic [XLEN-1:0]   e_data,
      input logic              w_en,
      input logic [REG_AW-1:0] w_rd,
      input logic [XLEN-1:0]   w_data
   );
      if (addr == '0)                 return rf;
      else if (e_en && e_rd == addr)  return e_data;
      else if (w_en && w_rd == addr)  return w_data;
      else                            return rf;
   endfunction

   // Forwarded source operands
   always_comb begin
      rs1_f_p0 = fwd_src(bus.rs1_addr, bus.rs1, ex_wr_en, ex_rd, ex_data, wb_wr_en, wb_rd, wb_data);
      rs2_f_p0 = fwd_src(bus.rs2_addr, bus.rs2, ex_wr_en, ex_rd, ex_data, wb_wr_en, wb_rd, wb_data);
   end
`else
   logic unused_fwd;

   // Register-file data used as-is; bypass ports are left dangling
   always_comb begin
      rs1_f_p0 = bus.rs1;
      rs2_f_p0 = bus.rs2;
   end

   assign unused_fwd = ^{ex_wr_en, ex_rd, ex_data, wb_wr_en, wb_rd, wb_data,
                         bus.rs1_addr, bus.rs2_addr};
`endif

   // Operand A/B muxes; reserved codes yield zero and flag the entry
   always_comb begin
      op_a_p0    = '0;
      op_b_p0    = '0;
      illegal_p0 = 1'b0;
      case (a_sel_e'(bus.a_sel))
         A_RS1:   op_a_p0 = rs1_f_p0;
         A_PC:    op_a_p0 = bus.pc;
         A_ZERO:  op_a_p0 = '0;
         default: illegal_p0 = 1'b1;
      endcase
      case (imm_sel_e'(bus.imme_sel))
         IMM_RS2:  op_b_p0 = rs2_f_p0;
         IMM_I:    op_b_p0 = imm_i;
         IMM_B:    op_b_p0 = imm_b;
         IMM_S:    op_b_p0 = imm_s;
         IMM_U:    op_b_p0 = imm_u;
         IMM_UJ:   op_b_p0 = imm_uj;
         IMM_FOUR: op_b_p0 = XLEN'(4);
         default:  illegal_p0 = 1'b1;
      endcase
   end

   assign in_ready  = !vld_p1 || bus.out_ready;
   assign accept_p0 = bus.in_valid && in_ready && !flush;

   // ---- p0 -> p1: one-entry pipe register ----
   // Valid tracks accept/drain/flush; data loads only on a live accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1         <= 1'b0;
         op_a_p1        <= '0;
         op_b_p1        <= '0;
         store_data_p1  <= '0;
         sel_illegal_p1 <= 1'b0;
      end else begin
         if (flush)
            vld_p1 <= 1'b0;
         else if (accept_p0)
            vld_p1 <= 1'b1;
         else if (bus.out_ready)
            vld_p1 <= 1'b0;
         if (accept_p0) begin
            op_a_p1        <= op_a_p0;
            op_b_p1        <= op_b_p0;
            store_data_p1  <= rs2_f_p0;
            sel_illegal_p1 <= illegal_p0;
         end
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = vld_p1;
   assign bus.op_a        = op_a_p1;
   assign bus.op_b        = op_b_p1;
   assign bus.store_data  = store_data_p1;
   assign bus.sel_illegal = sel_illegal_p1;

endmodule

// File: tb/tb_operand_sel_stage.sv
// Scoreboard bench for operand_sel_stage: the driver pushes the expected
// entry when an accept is due, the monitor compares the held entry every
// cycle and retires it on drain or flush.
module tb_operand_sel_stage;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] sd;
      logic            ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic ex_wr_en = 1'b0, wb_wr_en = 1'b0;
   logic [REG_AW-1:0] ex_rd = '0, wb_rd = '0;
   logic [XLEN-1:0]   ex_data = '0, wb_data = '0;

   int total = 0;
   int bad = 0;
   exp_t q[$];
   logic pend = 1'b0;
   exp_t pend_v;

   operand_sel_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

   operand_sel_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus),
      .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_data(ex_data),
      .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Sign-extend the low n bits of v
   function automatic logic [63:0] sx(input logic [63:0] v, input int n);
      logic [63:0] m;
      m = (64'd1 << n) - 64'd1;
      v = v & m;
      if (v[n-1]) return v - (64'd1 << n);
      return v;
   endfunction

   function automatic logic [XLEN-1:0] src(input logic [REG_AW-1:0] addr, input logic [XLEN-1:0] rf);
`ifdef OPSEL_FWD_EN
      if (addr != 0 && ex_wr_en && ex_rd == addr) return ex_data;
      if (addr != 0 && wb_wr_en && wb_rd == addr) return wb_data;
`endif
      return rf;
   endfunction

   function automatic exp_t model();
      exp_t e;
      logic [63:0] w, imm;
      w = {32'd0, bus.inst};
      e.ill = 1'b0;
      e.sd  = src(bus.rs2_addr, bus.rs2);
      case (bus.a_sel)
         2'd0: e.a = src(bus.rs1_addr, bus.rs1);
         2'd1: e.a = bus.pc;
         2'd2: e.a = '0;
         default: begin e.a = '0; e.ill = 1'b1; end
      endcase
      case (bus.imme_sel)
         3'd0: imm = {32'd0, src(bus.rs2_addr, bus.rs2)};
         3'd1: imm = sx(w >> 20, 12);
         3'd2: imm = sx((w[31] << 12) | (w[7] << 11) | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
         3'd3: imm = sx((((w >> 25) & 127) << 5) | ((w >> 7) & 31), 12);
         3'd4: imm = sx(w & 64'hFFFF_F000, 32);
         3'd5: imm = sx((w[31] << 20) | (((w >> 12) & 255) << 12) | (w[20] << 11) | (((w >> 21) & 1023) << 1), 21);
         3'd6: imm = 64'd4;
         default: begin imm = 64'd0; e.ill = 1'b1; end
      endcase
      e.b = imm[XLEN-1:0];
      return e;
   endfunction

   // Called at posedge+1 with inputs set; finishes at the next posedge+1
   task automatic step();
      pend = bus.in_valid && (q.size() == 0 || bus.out_ready) && !flush;
      if (pend) pend_v = model();
      @(posedge clk);
      if (pend) q.push_back(pend_v);
      pend = 1'b0;
      #1;
   endtask

   task automatic set_op(input logic [31:0] i, input logic [XLEN-1:0] r1, input logic [REG_AW-1:0] a1,
                         input logic [1:0] as, input logic [2:0] is);
      bus.in_valid = 1'b1; bus.inst = i; bus.rs1 = r1; bus.rs1_addr = a1;
      bus.a_sel = as; bus.imme_sel = is;
   endtask

   // Monitor: compare the held entry mid-cycle, retire on drain/flush
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("in_ready", bus.in_ready, (q.size() == 0) || bus.out_ready);
            chk("out_valid", bus.out_valid, q.size() != 0);
            if (q.size() != 0) begin
               e = q[0];
               if (bus.out_valid) begin
                  chk("op_a", bus.op_a, e.a);
                  chk("op_b", bus.op_b, e.b);
                  chk("store_data", bus.store_data, e.sd);
                  chk("sel_illegal", bus.sel_illegal, e.ill);
               end
               if (bus.out_ready || flush) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      bus.in_valid = 0; bus.inst = 0; bus.pc = 0; bus.rs1 = 0; bus.rs2 = 0;
      bus.rs1_addr = 0; bus.rs2_addr = 0; bus.a_sel = 0; bus.imme_sel = 0; bus.out_ready = 1;
      @(posedge clk); #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_op_a", bus.op_a, 0);
      chk("rst_op_b", bus.op_b, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      rst = 1'b0;

      // I immediate: addi x1,x0,-1
      set_op(32'hFFF0_0093, 32'd5, 5'd0, 2'b00, 3'b001);
      step();
      chk("i_out_valid", bus.out_valid, 1);
      chk("i_op_b", bus.op_b, 32'hFFFF_FFFF);
      chk("i_op_a", bus.op_a, 32'd5);

      // Forwarding priority on rs1
      set_op(32'h0000_0033, 32'h11, 5'd3, 2'b00, 3'b000);
      ex_wr_en = 1; ex_rd = 3; ex_data = 32'hAA; wb_wr_en = 1; wb_rd = 3; wb_data = 32'hBB;
      step();
`ifdef OPSEL_FWD_EN
      chk("fwd_ex", bus.op_a, 32'hAA);
`else
      chk("fwd_ex", bus.op_a, 32'h11);
`endif
      ex_wr_en = 0;
      step();
`ifdef OPSEL_FWD_EN
      chk("fwd_wb", bus.op_a, 32'hBB);
`else
      chk("fwd_wb", bus.op_a, 32'h11);
`endif
      bus.rs1_addr = 0; ex_wr_en = 1;
      step();
      chk("fwd_x0", bus.op_a, 32'h11);
      ex_wr_en = 0; wb_wr_en = 0;

      // B immediate (beq -4)
      set_op(32'hFE00_0EE3, 32'd0, 5'd0, 2'b01, 3'b010);
      bus.pc = 32'h100;
      step();
      chk("b_op_b", bus.op_b, 32'hFFFF_FFFC);
      chk("b_op_a_pc", bus.op_a, 32'h100);

      // Backpressure: held entry stays while a U op waits
      bus.out_ready = 0;
      set_op(32'h1234_5037, 32'd0, 5'd0, 2'b10, 3'b100);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_hold_op_b", bus.op_b, 32'hFFFF_FFFC);
      end
      bus.out_ready = 1;
      step();
      chk("u_op_b", bus.op_b, 32'h1234_5000);

      // Reserved encodings
      set_op(32'h0, 32'd9, 5'd0, 2'b11, 3'b111);
      step();
      chk("rsv_op_b", bus.op_b, 0);
      chk("rsv_op_a", bus.op_a, 0);
      chk("rsv_illegal", bus.sel_illegal, 1);

      // Flush drops a same-cycle accept
      set_op(32'h0010_0093, 32'd1, 5'd0, 2'b00, 3'b001);
      flush = 1;
      step();
      chk("flush_out_valid", bus.out_valid, 0);
      flush = 0;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         bus.in_valid = ($urandom_range(0, 9) < 7);
         bus.inst = $urandom; bus.pc = $urandom;
         bus.rs1 = $urandom; bus.rs2 = $urandom;
         bus.rs1_addr = REG_AW'($urandom_range(0, 7));
         bus.rs2_addr = REG_AW'($urandom_range(0, 7));
         bus.a_sel = 2'($urandom_range(0, 3));
         bus.imme_sel = 3'($urandom_range(0, 7));
         bus.out_ready = ($urandom_range(0, 9) < 7);
         flush = ($urandom_range(0, 19) == 0);
         ex_wr_en = $urandom_range(0, 1); ex_rd = REG_AW'($urandom_range(0, 7)); ex_data = $urandom;
         wb_wr_en = $urandom_range(0, 1); wb_rd = REG_AW'($urandom_range(0, 7)); wb_data = $urandom;
         step();
      end
      flush = 0;

      // Async reset while an entry is held under backpressure
      bus.out_ready = 0;
      set_op(32'hFFF0_0093, 32'd7, 5'd0, 2'b00, 3'b001);
      step();
      step();
      chk("pre_rst_valid", bus.out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", bus.out_valid, 0);
      chk("async_rst_op_a", bus.op_a, 0);
      chk("async_rst_op_b", bus.op_b, 0);
      chk("async_rst_sd", bus.store_data, 0);
      chk("async_rst_ill", bus.sel_illegal, 0);
      q.delete();
      bus.in_valid = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
